// File: rtl/pipe_elastic_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_elastic_stage_if : valid/ready/data handshake bundle                |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface pipe_elastic_stage_if #(
  parameter int WIDTH = 64
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface
`default_nettype wire

// File: rtl/pipe_elastic_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_elastic_stage : DEPTH-entry circular-buffer elastic pipeline stage  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module pipe_elastic_stage #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  pipe_elastic_stage_if.slave  up,
  pipe_elastic_stage_if.master dn,
  output logic [CW-1:0]        count
);

  localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push;
  logic             pop;

  // Handshake outputs depend only on registered occupancy: no out_ready->in_ready path.
  assign up.ready = (cnt_q != FULL_CNT);
  assign dn.valid = (cnt_q != '0);
  assign dn.data  = mem_q[rd_ptr_q];
  assign count    = cnt_q;

  assign push = up.valid & up.ready;
  assign pop  = dn.valid & dn.ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = up.data;
        wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_elastic_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pipe_elastic_stage : directed vectors for DEPTH=1/2/3 stage instances |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_pipe_elastic_stage;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       flush;
  logic [0:0] cnt1;
  logic [1:0] cnt2;
  logic [1:0] cnt3;

  pipe_elastic_stage_if #(.WIDTH(W)) up1 (), dn1 (), up2 (), dn2 (), up3 (), dn3 ();

  pipe_elastic_stage #(.WIDTH(W), .DEPTH(1)) u_d1 (
    .clk(clk), .reset(reset), .flush(flush), .up(up1), .dn(dn1), .count(cnt1));
  pipe_elastic_stage #(.WIDTH(W), .DEPTH(2)) u_d2 (
    .clk(clk), .reset(reset), .flush(flush), .up(up2), .dn(dn2), .count(cnt2));
  pipe_elastic_stage #(.WIDTH(W), .DEPTH(3)) u_d3 (
    .clk(clk), .reset(reset), .flush(flush), .up(up3), .dn(dn3), .count(cnt3));

  int errors = 0;
  int checks = 0;

  // sel: 0 = all instances, 1/2/3 = the instance with that DEPTH
  typedef struct {
    int sel; int rst; int fl; int iv; int id; int ordy;
    int e_ir; int e_ov; int e_od; int chk_od; int e_cnt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(int sel, int rst, int fl, int iv, int id, int ordy,
                              int e_ir, int e_ov, int e_od, int chk_od, int e_cnt);
    vec_t v;
    v.sel = sel; v.rst = rst; v.fl = fl; v.iv = iv; v.id = id; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.chk_od = chk_od; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input int sel, input int iv, input int d, input int ordy);
    up1.valid = (sel == 0 || sel == 1) ? iv[0] : 1'b0;
    up2.valid = (sel == 0 || sel == 2) ? iv[0] : 1'b0;
    up3.valid = (sel == 0 || sel == 3) ? iv[0] : 1'b0;
    up1.data  = d[W-1:0];
    up2.data  = d[W-1:0];
    up3.data  = d[W-1:0];
    dn1.ready = (sel == 0 || sel == 1) ? ordy[0] : 1'b0;
    dn2.ready = (sel == 0 || sel == 2) ? ordy[0] : 1'b0;
    dn3.ready = (sel == 0 || sel == 3) ? ordy[0] : 1'b0;
  endtask

  task automatic get_out(input int sel, output int ir, output int ov, output int od,
                         output int cnt);
    case (sel)
      1: begin ir = int'(up1.ready); ov = int'(dn1.valid); od = int'(dn1.data); cnt = int'(cnt1); end
      2: begin ir = int'(up2.ready); ov = int'(dn2.valid); od = int'(dn2.data); cnt = int'(cnt2); end
      default: begin ir = int'(up3.ready); ov = int'(dn3.valid); od = int'(dn3.data); cnt = int'(cnt3); end
    endcase
  endtask

  task automatic check_vec(input int idx, input vec_t v);
    int ir, ov, od, cnt;
    for (int s = 1; s <= 3; s++) begin
      if (v.sel == 0 || v.sel == s) begin
        get_out(s, ir, ov, od, cnt);
        chk($sformatf("v%0d.d%0d.in_ready", idx, s), ir, v.e_ir);
        chk($sformatf("v%0d.d%0d.out_valid", idx, s), ov, v.e_ov);
        chk($sformatf("v%0d.d%0d.count", idx, s), cnt, v.e_cnt);
        if (v.chk_od != 0)
          chk($sformatf("v%0d.d%0d.out_data", idx, s), od, v.e_od);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset / idle on all instances
    vq.push_back(mk(0, 1, 0, 1, 'hAA, 0,  1, 0, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 'hAA, 0,  1, 0, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 'h00, 0,  1, 0, 0, 1, 0));
    // DEPTH=2 streaming 1..8 with out_ready held high
    vq.push_back(mk(2, 0, 0, 1, 1, 1,  1, 0, 0, 0, 0));
    for (int k = 1; k <= 7; k++)
      vq.push_back(mk(2, 0, 0, 1, k + 1, 1,  1, 1, k, 1, 1));
    vq.push_back(mk(2, 0, 0, 0, 0, 1,  1, 1, 8, 1, 1));
    vq.push_back(mk(2, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0));
    // DEPTH=3 backpressure / full
    vq.push_back(mk(3, 0, 0, 1, 'h10, 0,  1, 0, 0,    0, 0));
    vq.push_back(mk(3, 0, 0, 1, 'h11, 0,  1, 1, 'h10, 1, 1));
    vq.push_back(mk(3, 0, 0, 1, 'h12, 0,  1, 1, 'h10, 1, 2));
    vq.push_back(mk(3, 0, 0, 1, 'h13, 0,  0, 1, 'h10, 1, 3));
    vq.push_back(mk(3, 0, 0, 1, 'h13, 0,  0, 1, 'h10, 1, 3));
    vq.push_back(mk(3, 0, 0, 1, 'h13, 1,  0, 1, 'h10, 1, 3));
    vq.push_back(mk(3, 0, 0, 1, 'h13, 1,  1, 1, 'h11, 1, 2));
    vq.push_back(mk(3, 0, 0, 0, 0,    1,  1, 1, 'h12, 1, 2));
    vq.push_back(mk(3, 0, 0, 0, 0,    1,  1, 1, 'h13, 1, 1));
    vq.push_back(mk(3, 0, 0, 0, 0,    0,  1, 0, 0,    0, 0));
    // DEPTH=3 flush with a simultaneous push
    vq.push_back(mk(3, 0, 0, 1, 'h20, 0,  1, 0, 0,    0, 0));
    vq.push_back(mk(3, 0, 0, 1, 'h21, 0,  1, 1, 'h20, 1, 1));
    vq.push_back(mk(3, 0, 1, 1, 'h22, 0,  1, 1, 'h20, 1, 2));
    vq.push_back(mk(3, 0, 0, 1, 'h23, 0,  1, 0, 0,    0, 0));
    vq.push_back(mk(3, 0, 0, 0, 0,    1,  1, 1, 'h23, 1, 1));
    vq.push_back(mk(3, 0, 0, 0, 0,    0,  1, 0, 0,    0, 0));
    // DEPTH=1: in_ready alternates, one transfer per two cycles
    vq.push_back(mk(1, 0, 0, 1, 'h31, 1,  1, 0, 0,    0, 0));
    vq.push_back(mk(1, 0, 0, 1, 'h32, 1,  0, 1, 'h31, 1, 1));
    vq.push_back(mk(1, 0, 0, 1, 'h32, 1,  1, 0, 0,    0, 0));
    vq.push_back(mk(1, 0, 0, 1, 'h33, 1,  0, 1, 'h32, 1, 1));
    vq.push_back(mk(1, 0, 0, 1, 'h33, 1,  1, 0, 0,    0, 0));
    vq.push_back(mk(1, 0, 0, 0, 0,    1,  0, 1, 'h33, 1, 1));
    vq.push_back(mk(1, 0, 0, 0, 0,    0,  1, 0, 0,    0, 0));

    reset = 1'b1;
    flush = 1'b0;
    drive(0, 1, 'hAA, 0);
    @(posedge clk);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      reset = vq[i].rst[0];
      flush = vq[i].fl[0];
      drive(vq[i].sel, vq[i].iv, vq[i].id, vq[i].ordy);
      #1;
      check_vec(i, vq[i]);
    end

    // DEPTH=3 wrap-around with random stalls, checked against a queue model
    begin : wrap
      int sb[$];
      int nxt;
      int pushes;
      int pops;
      int ordy;
      int ir, ov, od, cnt;
      bit do_push, do_pop;
      nxt = 'h40;
      pushes = 0;
      pops = 0;
      for (int c = 0; c < 50; c++) begin
        @(negedge clk);
        reset = 1'b0;
        flush = 1'b0;
        ordy  = (c < 40) ? int'($urandom_range(0, 1)) : 1;
        drive(3, (c < 40) ? 1 : 0, nxt, ordy);
        #1;
        get_out(3, ir, ov, od, cnt);
        chk($sformatf("wrap%0d.in_ready", c), ir, (sb.size() != 3) ? 1 : 0);
        chk($sformatf("wrap%0d.out_valid", c), ov, (sb.size() != 0) ? 1 : 0);
        chk($sformatf("wrap%0d.count", c), cnt, sb.size());
        if (sb.size() != 0)
          chk($sformatf("wrap%0d.out_data", c), od, sb[0]);
        do_push = (c < 40) && (sb.size() != 3);
        do_pop  = (sb.size() != 0) && (ordy != 0);
        if (do_pop) begin
          void'(sb.pop_front());
          pops++;
        end
        if (do_push) begin
          sb.push_back(nxt);
          nxt = (nxt + 1) & 'hFF;
          pushes++;
        end
      end
      chk("wrap.pops_at_least_10", (pops >= 10) ? 1 : 0, 1);
      chk("wrap.lossless_pops", pops, pushes);
    end

    @(negedge clk);
    drive(0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_elastic_stage.md
# pipe_elastic_stage

Parametrised elastic pipeline stage between two backend stages (e.g. MEM→WB), carrying an opaque control/data bus under a valid/ready handshake. Holds up to DEPTH entries in a circular buffer, so the stage sustains one transfer per cycle while the downstream stalls. No combinational path runs from out_ready to in_ready. A synchronous flush discards everything in flight on redirect or exception.

## Interface
- WIDTH, 64, bus width in bits (≥1)
- DEPTH, 2, buffer entries (≥1; any integer, power of two not required)
- CW, $clog2(DEPTH+1), width of the occupancy count (derived, not overridden)

- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high
- flush  input  1  discard all entries; sampled at rising edge
- in_valid  input  1  upstream has data on in_data
- in_ready  output  1  stage can accept one entry this cycle
- in_data  input  WIDTH  upstream bus
- out_valid  output  1  out_data holds a valid entry
- out_ready  input  1  downstream accepts this cycle
- out_data  output  WIDTH  head entry
- count  output  CW  current occupancy, 0..DEPTH

## Operation
- push = in_valid & in_ready. pop = out_valid & out_ready.
- Storage: DEPTH×WIDTH registers, write pointer wr_ptr, read pointer rd_ptr, occupancy register cnt.
- Each pointer advances by 1 on its event. It wraps from DEPTH-1 to 0 by explicit compare, not modulo 2^n.
- in_ready = (cnt != DEPTH). This is purely registered state and independent of out_ready.
- out_valid = (cnt != 0).
- out_data = mem[rd_ptr], driven directly from storage with no output mux on in_data.
- count = cnt.
- Occupancy update:
  - push only: cnt+1
  - pop only: cnt-1
  - push and pop together: cnt unchanged, both pointers advance
- A push writes mem[wr_ptr] <= in_data. No entry is overwritten before it is popped.
- Flush has priority over push and pop:
  - cnt <= 0, wr_ptr <= 0, rd_ptr <= 0.
  - A push presented in the flush cycle is dropped.
  - A pop in the flush cycle counts as the downstream consuming the head, but no state remains afterwards.
  - Storage contents are not cleared by flush.
- reset has priority over flush. It clears cnt, both pointers, and every storage entry to 0.
- in_valid/in_data may change freely while in_ready=0; the stage ignores them.
- The stage drives out_valid/out_data stable from one cycle to the next until a pop or flush.

## Timing
- Reset values, held the cycle after reset is sampled high:
  - in_ready=1, out_valid=0, out_data=0, count=0
- Latency: an entry pushed at edge N appears on out_valid/out_data after edge N (cycle N+1). There is no same-cycle bypass.
- Throughput:
  - DEPTH≥2: one transfer per cycle sustained, with in_valid and out_ready held high.
  - DEPTH=1: one transfer per two cycles. in_ready drops while full even if out_ready=1.
- Full (cnt=DEPTH): in_ready=0. Any simultaneous out_ready=1 pops, and in_ready returns to 1 in the next cycle.
- Empty (cnt=0): out_valid=0 and out_ready is ignored. The cnt update is guarded so it never underflows.
- Wrap-around: the pointer sequence for DEPTH=3 is 0,1,2,0,… Data order is preserved across the wrap.
- Flush or reset in mid-operation: takes effect at that edge. The next cycle shows out_valid=0, count=0, in_ready=1.

## Test plan
- Reset/idle:
  - Assert reset 2 cycles with in_valid=1, in_data=0xAA.
  - Required: out_valid=0, out_data=0, count=0, in_ready=1 throughout and one cycle after release.
- Streaming, DEPTH=2:
  - Push 0x1..0x8 on consecutive cycles with out_ready=1.
  - Required: out_data 0x1..0x8 in order, starting one cycle after the first push, with no bubbles. count stays ≤1.
- Backpressure/full, DEPTH=3:
  - Hold out_ready=0 and push 0x10,0x11,0x12,0x13.
  - Required: in_ready=0 after the 3rd push, count=3, and 0x13 is held off.
  - Then out_ready=1: outputs 0x10,0x11,0x12,0x13 in order, with in_ready=1 in the cycle after the first pop.
- Wrap, DEPTH=3:
  - Run 10 push/pop cycles with random out_ready stalls (~50%).
  - Required: scoreboard shows in-order, lossless, duplicate-free delivery across ≥3 pointer wraps.
- Flush:
  - With count=2 (0x20,0x21) and a push of 0x22 in the same cycle, assert flush.
  - Required: next cycle count=0, out_valid=0, and 0x22 is never delivered.
  - A subsequent push of 0x23 appears alone.
- DEPTH=1:
  - Continuous in_valid=1 and out_ready=1.
  - Required: in_ready toggles 1,0,1,0…, giving exactly one transfer per 2 cycles.
